mkmif_spi: RTL
==============

// Module: mkmif_spi
// PURPOSE
//  SPI master engine under the MKM interface core; shifts a byte-length-framed command/address/data
//  sequence out to a 23K640 serial SRAM (SPI mode 0, MSB first) and captures the trailing 32 read bits.
//  The control FSM above loads a frame with set, launches it with start and waits for ready.
// PARAMETERS
//  none. Widths fixed: frame 56 b (7 bytes), read capture 32 b, divisor 16 b.
// PORTS
//  clk       in   1   system clock
//  reset_n   in   1   asynchronous, active-low reset
//  spi_sclk  out  1   SPI clock to SRAM, idles low
//  spi_cs_n  out  1   SRAM chip select, active low
//  spi_do    in   1   serial data from SRAM (MISO)
//  spi_di    out  1   serial data to SRAM (MOSI)
//  set       in   1   load wr_data/length into frame registers (accepted only when ready=1)
//  start     in   1   begin transfer of loaded frame (accepted only when ready=1)
//  length    in   3   frame length in bytes, 0..7
//  divisor   in   16  SCLK half-period in clk cycles; 0 treated as 1
//  ready     out  1   1 = idle, will accept set/start
//  wr_data   in   56  frame, sent from bit 55 downward; only the top 8*length bits are sent
//  rd_data   out  32  last 32 bits sampled from spi_do, bit 0 = most recently sampled bit
// BEHAVIOUR
//  Reset (async): spi_sclk=0, spi_cs_n=1, spi_di=0, ready=1, rd_data=0, frame regs=0, FSM IDLE.
//  d = max(divisor,1), sampled at accepted start; divisor changes mid-transfer have no effect.
//  FSM: IDLE -> CS_SETUP -> {SCLK_HIGH -> SCLK_LOW}* -> CS_HOLD -> IDLE. Each non-IDLE state lasts d cycles.
//  IDLE: ready=1, cs_n=1, sclk=0. start with length!=0 -> CS_SETUP (ready=0, cs_n=0 next cycle).
//   start with length==0: no CS assertion, no SCLK; ready drops for exactly 1 cycle, rd_data unchanged.
//  CS_SETUP: sclk=0, spi_di=frame[55]. -> SCLK_HIGH.
//  SCLK_HIGH: sclk=1. On its last cycle: sample spi_do into rd_data (shift left), shift frame left 1,
//   decrement bit count (init 8*length). Count becomes 0 -> CS_HOLD, else -> SCLK_LOW.
//  SCLK_LOW: sclk=0, spi_di=frame[55] (new bit presented on falling edge). -> SCLK_HIGH.
//  CS_HOLD: sclk=0, cs_n=0. On exit cs_n=1 and ready=1 in the same cycle.
//  CS low duration = d*(1+16*length) cycles; exactly 8*length SCLK rising edges per frame.
//  set+start in same ready cycle: both accepted; transfer uses the newly loaded frame/length.
//  set or start while ready=0: ignored, no side effects. set alone never changes pins.
//  rd_data updates only during SCLK_HIGH sampling; stable while ready=1.
//  Reset mid-transfer: immediate return to reset values; cs_n rises asynchronously.
// CONFIGURATION
//  MKMIF_SPI_CS_GAP_EN defined: after cs_n rises, FSM enters CS_GAP for d cycles (cs_n=1, sclk=0,
//   ready=0) before IDLE, guaranteeing SRAM deselect time between back-to-back frames.
//  Undefined: no CS_GAP state; ready=1 in the same cycle cs_n rises.
// STRUCTURE
//  mkmif_pkg: FSM state encodings, SPI command opcodes (READ 8'h03, WRITE 8'h02, RDSR 8'h05,
//   WRSR 8'h01), SEQ_MODE_NO_HOLD 8'h41, frame/capture width constants.
//  Sub-module mkmif_spi_clkgen: 16-bit half-period counter; inputs restart/enable/d, output tick
//   asserted on the last cycle of each d-cycle phase. Rest (FSM, shift regs, bit counter) in this file.
// TESTING
//  1 Reset: hold reset_n=0 -> sclk=0, cs_n=1, di=0, ready=1, rd_data=0; release -> outputs unchanged.
//  2 set wr_data={8'h01,8'h41,40'h0}, length=2, divisor=2, start -> MOSI bytes 01,41; 16 rising
//    edges; cs_n low 66 cycles; ready=1 when cs_n rises.
//  3 length=7 wr_data={8'h03,16'h0010,32'h0}, divisor=1, slave model drives 32'hDEADBEEF in bytes 4..7
//    -> 56 rising edges, rd_data=32'hDEADBEEF, cs_n low 113 cycles.
//  4 start with length=0 -> cs_n stays 1, no sclk edge, ready low 1 cycle, rd_data unchanged.
//  5 divisor=0 -> behaves as 1; divisor changed to 5 and set/start pulsed mid-transfer -> ignored,
//    frame timing and data unchanged.
//  6 assert reset_n=0 mid-frame (after 10 sclk edges) -> cs_n=1, sclk=0, ready=1 immediately;
//    subsequent length=2 frame correct. With MKMIF_SPI_CS_GAP_EN: ready lags cs_n rise by d cycles.

Source files
------------

// File: rtl/mkmif_spi_pkg.sv
// mkmif_spi_pkg: shared state encoding, 23K640 opcodes and width constants for the SPI engine
package mkmif_spi_pkg;
  localparam int FRAME_W = 56;
  localparam int RD_W    = 32;
  localparam int DIV_W   = 16;
  localparam int LEN_W   = 3;
  localparam int BITS_W  = 6;
  localparam logic [7:0] CMD_READ         = 8'h03;
  localparam logic [7:0] CMD_WRITE        = 8'h02;
  localparam logic [7:0] CMD_RDSR         = 8'h05;
  localparam logic [7:0] CMD_WRSR         = 8'h01;
  localparam logic [7:0] SEQ_MODE_NO_HOLD = 8'h41;
  typedef enum logic [2:0] {
    S_IDLE,
    S_NULL,
    S_CS_SETUP,
    S_SCLK_HIGH,
    S_SCLK_LOW,
    S_CS_HOLD,
    S_CS_GAP
  } state_t;
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction
endpackage

// File: rtl/mkmif_spi_if.sv
// mkmif_spi_if: control handshake and SPI pins between the MKM control FSM, the engine and the SRAM
interface mkmif_spi_if;
  logic        set;
  logic        start;
  logic [2:0]  length;
  logic [15:0] divisor;
  logic        ready;
  logic [55:0] wr_data;
  logic [31:0] rd_data;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_do;
  logic        spi_di;
  modport slave (
    input  set, start, length, divisor, wr_data, spi_do,
    output ready, rd_data, spi_sclk, spi_cs_n, spi_di
  );
  modport master (
    output set, start, length, divisor, wr_data, spi_do,
    input  ready, rd_data, spi_sclk, spi_cs_n, spi_di
  );
endinterface

// File: rtl/mkmif_spi_clkgen.sv
// mkmif_spi_clkgen: d-cycle phase timer; tick_o marks the last cycle of each phase
module mkmif_spi_clkgen
  import mkmif_spi_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] d_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  assign tick_o = enable_i && (cnt_q == d_i - DIV_W'(1));
  always_comb cnt_d = restart_i ? '0 : !enable_i ? cnt_q : tick_o ? '0 : cnt_q + DIV_W'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mkmif_spi.sv
// mkmif_spi: SPI mode-0 master shifting a byte-framed command out to a 23K640 SRAM
// MKMIF_SPI_CS_GAP_EN adds a d-cycle deselect gap after every frame before ready returns.
module mkmif_spi
  import mkmif_spi_pkg::*;
(
  input logic        clk,
  input logic        reset_n,
  mkmif_spi_if.slave bus
);
  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [BITS_W-1:0]  bits_q, bits_d;
  logic [DIV_W-1:0]   d_q, d_d;
  logic [RD_W-1:0]    rd_q, rd_d;
  logic [LEN_W-1:0]   go_len;
  logic               idle, tick;
  assign idle = state_q inside {S_IDLE, S_NULL};
  mkmif_spi_clkgen u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart_i (idle),
    .enable_i  (!idle),
    .d_i       (d_q),
    .tick_o    (tick)
  );
  // a same-cycle set+start launches with the freshly loaded length
  assign go_len = bus.set ? bus.length : len_q;
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    len_d   = len_q;
    bits_d  = bits_q;
    d_d     = d_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.set) begin
          frame_d = bus.wr_data;
          len_d   = bus.length;
        end
        if (bus.start) begin
          d_d     = eff_div(bus.divisor);
          bits_d  = {go_len, 3'b000};
          state_d = (go_len == '0) ? S_NULL : S_CS_SETUP;
        end
      end
      S_NULL: state_d = S_IDLE;
      S_CS_SETUP: state_d = tick ? S_SCLK_HIGH : S_CS_SETUP;
      S_SCLK_HIGH: if (tick) begin
        rd_d    = {rd_q[RD_W-2:0], bus.spi_do};
        frame_d = frame_q << 1;
        bits_d  = bits_q - BITS_W'(1);
        state_d = (bits_q == BITS_W'(1)) ? S_CS_HOLD : S_SCLK_LOW;
      end
      S_SCLK_LOW: state_d = tick ? S_SCLK_HIGH : S_SCLK_LOW;
`ifdef MKMIF_SPI_CS_GAP_EN
      S_CS_HOLD: state_d = tick ? S_CS_GAP : S_CS_HOLD;
`else
      S_CS_HOLD: state_d = tick ? S_IDLE : S_CS_HOLD;
`endif
      S_CS_GAP: state_d = tick ? S_IDLE : S_CS_GAP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      len_q   <= '0;
      bits_q  <= '0;
      d_q     <= DIV_W'(1);
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      len_q   <= len_d;
      bits_q  <= bits_d;
      d_q     <= d_d;
      rd_q    <= rd_d;
    end
  // pins decode straight from state so reset drops chip select without waiting for a clock
  assign bus.ready    = state_q == S_IDLE;
  assign bus.spi_sclk = state_q == S_SCLK_HIGH;
  assign bus.spi_cs_n = !(state_q inside {S_CS_SETUP, S_SCLK_HIGH, S_SCLK_LOW, S_CS_HOLD});
  assign bus.spi_di   = (state_q inside {S_CS_SETUP, S_SCLK_HIGH, S_SCLK_LOW}) && frame_q[FRAME_W-1];
  assign bus.rd_data  = rd_q;
endmodule
